// File: rtl/phf_multi_ctl.sv
// phf_multi_ctl: command target serving N_CH photon-hit-filter channels from one cmd/rsp
// FIFO pair; decodes CLEAR (per-channel handshake with timeout) and GET_STATUS.
module phf_multi_ctl #(
   parameter int unsigned N_CH        = 4,
   parameter logic [7:0]  TARGET_ID   = 8'h03,
   parameter logic [7:0]  OP_CLEAR    = 8'h01,
   parameter logic [7:0]  OP_STATUS   = 8'h02,
   parameter int unsigned CLR_TIMEOUT = 1000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     cmd_data,
   input  logic            cmd_waitreq,
   output logic            cmd_rdreq,
   output logic [31:0]     rsp_data,
   input  logic            rsp_waitreq,
   output logic            rsp_wrreq,
   output logic [N_CH-1:0] phf_clear_req,
   input  logic [N_CH-1:0] phf_clear_busy,
   input  logic [N_CH-1:0] phf_status,
   output logic            phf_rsp_rdy
);
   localparam int unsigned     CNT_W    = $clog2(CLR_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_DECODE,
      S_CLR_REQ,
      S_CLR_WAIT,
      S_RSP
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       tgt_q, tgt_d;
   logic [7:0]       op_q, op_d;
   logic [N_CH-1:0]  mask_q, mask_d;
   logic [N_CH-1:0]  req_q, req_d;
   logic [N_CH-1:0]  ack_q, ack_d;
   logic [15:0]      res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0]  unfinished;
   logic             clr_done;
   logic             unused_payload;

   // A masked channel is still outstanding until it has acked and dropped busy again.
   assign unfinished     = mask_q & (~ack_q | phf_clear_busy);
   assign clr_done       = (unfinished == '0);
   assign unused_payload = ^cmd_data[15:N_CH];

   assign rsp_data      = {tgt_q, op_q, res_q};
   assign phf_clear_req = req_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tgt_q   <= '0;
         op_q    <= '0;
         mask_q  <= '0;
         req_q   <= '0;
         ack_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         op_q    <= op_d;
         mask_q  <= mask_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      op_d        = op_q;
      mask_d      = mask_q;
      req_d       = req_q;
      ack_d       = ack_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      cmd_rdreq   = 1'b0;
      rsp_wrreq   = 1'b0;
      phf_rsp_rdy = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!cmd_waitreq) begin
               state_d = S_POP;
            end
         end
         S_POP: begin
            // Show-ahead FIFO: the word is already on cmd_data while we pop it.
            cmd_rdreq = 1'b1;
            tgt_d     = cmd_data[31:24];
            op_d      = cmd_data[23:16];
            mask_d    = cmd_data[N_CH-1:0];
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_RSP;
            if (tgt_q != TARGET_ID) begin
               res_d = 16'hFFFE;
            end else if (op_q == OP_STATUS) begin
               res_d = 16'(phf_status);
            end else if (op_q == OP_CLEAR) begin
               res_d = 16'h0000;
               if (mask_q != '0) begin
                  state_d = S_CLR_REQ;
               end
            end else begin
               res_d = 16'hFFFF;
            end
         end
         S_CLR_REQ: begin
            req_d   = mask_q;
            ack_d   = '0;
            cnt_d   = '0;
            state_d = S_CLR_WAIT;
         end
         S_CLR_WAIT: begin
            ack_d = ack_q | (req_q & phf_clear_busy);
            req_d = req_q & ~phf_clear_busy;
            cnt_d = cnt_q + CNT_W'(1);
            // Completion is checked first so it wins over a simultaneous timeout.
            if (clr_done) begin
               req_d   = '0;
               res_d   = 16'h0000;
               state_d = S_RSP;
            end else if (cnt_q == CNT_LAST) begin
               req_d   = '0;
               res_d   = {1'b1, 15'(unfinished)};
               state_d = S_RSP;
            end
         end
         S_RSP: begin
            if (!rsp_waitreq) begin
               rsp_wrreq   = 1'b1;
               phf_rsp_rdy = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule
